ex_mem_reg: RTL

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/ex_mem_reg.sv | 114 +++++++++++
 1 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register. It captures the EX-stage results with stall and flush control.
// It also keeps a saturating count of the bubbles it has inserted.
module ex_mem_reg #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Stall,
    input  logic                Flush,
    input  logic                ValidIn,
    input  logic                RegWriteIn,
    input  logic                MemtoRegIn,
    input  logic                BranchIn,
    input  logic                MemReadIn,
    input  logic                MemWriteIn,
    input  logic                ZeroIn,
    input  logic [WIDTH-1:0]    BranchTargetIn,
    input  logic [WIDTH-1:0]    ALUResultIn,
    input  logic [WIDTH-1:0]    WriteDataIn,
    input  logic [REG_BITS-1:0] WriteRegIn,
    output logic                ValidOut,
    output logic                RegWrite,
    output logic                MemtoReg,
    output logic                Branch,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                Zero,
    output logic [WIDTH-1:0]    BranchTarget,
    output logic [WIDTH-1:0]    ALUResult,
    output logic [WIDTH-1:0]    WriteData,
    output logic [REG_BITS-1:0] WriteReg,
    output logic [15:0]         BubbleCount
);

    logic                r_valid;
    logic                r_reg_write;
    logic                r_mem_to_reg;
    logic                r_branch;
    logic                r_mem_read;
    logic                r_mem_write;
    logic                r_zero;
    logic [WIDTH-1:0]    r_branch_target;
    logic [WIDTH-1:0]    r_alu_result;
    logic [WIDTH-1:0]    r_write_data;
    logic [REG_BITS-1:0] r_write_reg;
    logic [15:0]         r_bubble_count;

    logic w_load;
    logic w_bubble;
    logic w_count_sat;

    // A flush overrides a stall. A non-stalled invalid EX slot is also a bubble.
    assign w_load      = Flush | ~Stall;
    assign w_bubble    = Flush | (~Stall & ~ValidIn);
    assign w_count_sat = (r_bubble_count == 16'hFFFF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid        <= 1'b0;
            r_reg_write    <= 1'b0;
            r_mem_to_reg   <= 1'b0;
            r_branch       <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
        end else if (w_load) begin
            r_valid        <= ~w_bubble;
            r_reg_write    <= ~w_bubble & RegWriteIn;
            r_mem_to_reg   <= ~w_bubble & MemtoRegIn;
            r_branch       <= ~w_bubble & BranchIn;
            r_mem_read     <= ~w_bubble & MemReadIn;
            r_mem_write    <= ~w_bubble & MemWriteIn;
        end
    end

    // Datapath fields load even on bubbles, so their content stays deterministic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zero          <= 1'b0;
            r_branch_target <= '0;
            r_alu_result    <= '0;
            r_write_data    <= '0;
            r_write_reg     <= '0;
        end else if (w_load) begin
            r_zero          <= ZeroIn;
            r_branch_target <= BranchTargetIn;
            r_alu_result    <= ALUResultIn;
            r_write_data    <= WriteDataIn;
            r_write_reg     <= WriteRegIn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bubble_count <= 16'h0000;
        end else if (w_bubble && !w_count_sat) begin
            r_bubble_count <= r_bubble_count + 16'h0001;
        end
    end

    assign ValidOut     = r_valid;
    assign RegWrite     = r_reg_write;
    assign MemtoReg     = r_mem_to_reg;
    assign Branch       = r_branch;
    assign MemRead      = r_mem_read;
    assign MemWrite     = r_mem_write;
    assign Zero         = r_zero;
    assign BranchTarget = r_branch_target;
    assign ALUResult    = r_alu_result;
    assign WriteData    = r_write_data;
    assign WriteReg     = r_write_reg;
    assign BubbleCount  = r_bubble_count;

endmodule
